// File: rtl/mem_pkg.sv
// mem_pkg: shared op codes, responder states and data widths for the data-memory path
package mem_pkg;
    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;
    localparam int WORD_W = 32;
    typedef enum logic [2:0] {
        OP_LB  = 3'b000,
        OP_LH  = 3'b001,
        OP_LW  = 3'b010,
        OP_LBU = 3'b011,
        OP_LHU = 3'b100,
        OP_SB  = 3'b101,
        OP_SH  = 3'b110,
        OP_SW  = 3'b111
    } mem_op_t;
    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        WRITE,
        RESP
    } dmem_state_t;
endpackage

// File: rtl/dmem_lane_unit.sv
// dmem_lane_unit: load lane extraction, sub-word store merge and misalignment detection
module dmem_lane_unit
    import mem_pkg::*;
(
    input  mem_op_t            op,
    input  logic [1:0]         addr,
    input  logic [WORD_W-1:0]  word,
    input  logic [WORD_W-1:0]  wdata,
    output logic [WORD_W-1:0]  rdata,
    output logic [WORD_W-1:0]  mword,
    output logic               misaligned
);
    logic [BYTE_W-1:0] byte_v;
    logic [HALF_W-1:0] half_v;
    always_comb begin
        byte_v = word[{addr, 3'b000} +: BYTE_W];
        half_v = addr[1] ? word[WORD_W-1:HALF_W] : word[HALF_W-1:0];
        rdata = (op == OP_LB || op == OP_LBU) ? {{(WORD_W-BYTE_W){1'b0}}, byte_v} :
                (op == OP_LH || op == OP_LHU) ? {{(WORD_W-HALF_W){1'b0}}, half_v} :
                (op == OP_LW)                 ? word : '0;
        mword = word;
        if (op == OP_SB) mword[{addr, 3'b000} +: BYTE_W] = wdata[BYTE_W-1:0];
        if (op == OP_SH) mword[{addr[1], 4'b0000} +: HALF_W] = wdata[HALF_W-1:0];
        if (op == OP_SW) mword = wdata;
        misaligned = ((op == OP_LH || op == OP_LHU || op == OP_SH) && addr[0]) ||
                     ((op == OP_LW || op == OP_SW) && addr != 2'b00);
    end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: one-in-flight load/store responder in front of a word-wide RAM without byte enables
module dmem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_ctrl,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-3:0] ram_addr,
    output logic              ram_we,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);
    dmem_state_t       state, state_nx;
    mem_op_t           op_q, lu_op;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q, mrg_q;
    logic [1:0]        lu_addr;
    logic [31:0]       lu_wdata, lu_rdata, lu_mword;
    logic              lu_mis;
    logic              accept;
    // In IDLE the lane unit looks at the live request so misalignment is known at the accept edge
    assign lu_op    = (state == IDLE) ? mem_op_t'(req_ctrl) : op_q;
    assign lu_addr  = (state == IDLE) ? req_addr[1:0] : addr_q[1:0];
    assign lu_wdata = (state == IDLE) ? req_wdata : wdata_q;
    assign accept   = (state == IDLE) && req_valid;
    dmem_lane_unit u_lane (
        .op         (lu_op),
        .addr       (lu_addr),
        .word       (ram_rdata),
        .wdata      (lu_wdata),
        .rdata      (lu_rdata),
        .mword      (lu_mword),
        .misaligned (lu_mis)
    );
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_q      <= OP_LB;
            addr_q    <= '0;
            wdata_q   <= '0;
            mrg_q     <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                op_q      <= mem_op_t'(req_ctrl);
                addr_q    <= req_addr;
                wdata_q   <= req_wdata;
                mrg_q     <= req_wdata;
                rsp_rdata <= '0;
                rsp_err   <= lu_mis;
            end
            if (state == RD_WAIT) begin
                rsp_rdata <= lu_rdata;
                mrg_q     <= lu_mword;
            end
        end
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     state_nx = !req_valid ? IDLE : lu_mis ? RESP :
                                 (mem_op_t'(req_ctrl) == OP_SW) ? WRITE : RD_ISSUE;
            RD_ISSUE: state_nx = RD_WAIT;
            RD_WAIT:  state_nx = (op_q == OP_SB || op_q == OP_SH) ? WRITE : RESP;
            WRITE:    state_nx = RESP;
            RESP:     state_nx = rsp_ready ? IDLE : RESP;
            default:  state_nx = IDLE;
        endcase
    end
    always_comb begin
        req_ready = rst_n && (state == IDLE);
        rsp_valid = rst_n && (state == RESP);
        ram_we    = rst_n && (state == WRITE);
        ram_addr  = addr_q[ADDR_W-1:2];
        ram_wdata = mrg_q;
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized and directed checks of dmem_responder against a word-array reference
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_ctrl = '0;
    logic [11:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [9:0]  ram_addr;
    logic        ram_we;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic [31:0] mem [1024];
    logic [31:0] ref_mem [1024];
    logic        bd_we = 1'b0;
    logic [9:0]  bd_addr = '0;
    logic [31:0] bd_data = '0;
    int n_tests = 0;
    int n_fail = 0;

    dmem_responder #(.ADDR_W(12)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_ctrl(req_ctrl),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic poke(input int w, input logic [31:0] d);
        @(negedge clk);
        bd_we = 1'b1; bd_addr = w[9:0]; bd_data = d;
        @(posedge clk);
        #1 bd_we = 1'b0;
        ref_mem[w] = d;
    endtask

    // Expected outcome of one op, straight from the op-code rules; updates the reference memory
    task automatic ref_apply(input logic [2:0] c, input logic [11:0] a, input logic [31:0] wd,
                             output logic [31:0] rd, output logic e, output int lat);
        int w = int'(a[11:2]);
        int sh = int'(a[1:0]) * 8;
        int hs = a[1] ? 16 : 0;
        logic [31:0] cur = ref_mem[w];
        logic mis = ((c == 3'd1 || c == 3'd4 || c == 3'd6) && a[0]) ||
                    ((c == 3'd2 || c == 3'd7) && a[1:0] != 2'b00);
        rd = '0; e = mis; lat = 1;
        if (!mis) begin
            case (c)
                3'd0, 3'd3: begin rd = (cur >> sh) & 32'hFF; lat = 3; end
                3'd1, 3'd4: begin rd = (cur >> hs) & 32'hFFFF; lat = 3; end
                3'd2:       begin rd = cur; lat = 3; end
                3'd5: begin ref_mem[w] = (cur & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh); lat = 4; end
                3'd6: begin ref_mem[w] = (cur & ~(32'hFFFF << hs)) | ((wd & 32'hFFFF) << hs); lat = 4; end
                default: begin ref_mem[w] = wd; lat = 2; end
            endcase
        end
    endtask

    task automatic run_txn(input logic [2:0] c, input logic [11:0] a, input logic [31:0] wd,
                           input int hold, input bit busy_req,
                           output logic [31:0] rd, output logic e, output int lat,
                           output int nwe, output int we_cyc, output logic [9:0] we_addr,
                           output logic [31:0] we_data, output bit stable, output bit rdy_seen);
        rd = '0; e = 1'b0; lat = -1; nwe = 0; we_cyc = -1; we_addr = '0; we_data = '0;
        stable = 1'b1; rdy_seen = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_ctrl = c; req_addr = a; req_wdata = wd; rsp_ready = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int cyc = 1; cyc <= 20 && lat < 0; cyc++) begin
            @(negedge clk);
            if (req_ready) rdy_seen = 1'b1;
            if (ram_we) begin nwe++; we_cyc = cyc; we_addr = ram_addr; we_data = ram_wdata; end
            if (rsp_valid) begin lat = cyc; rd = rsp_rdata; e = rsp_err; end
        end
        if (lat < 0) return;
        if (busy_req) begin req_valid = 1'b1; req_ctrl = 3'd2; req_addr = 12'h000; end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_rdata !== rd || rsp_err !== e) stable = 1'b0;
            if (req_ready) rdy_seen = 1'b1;
            if (ram_we) nwe++;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0; req_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({req_ready, rsp_valid, rsp_err, ram_we} !== 4'b0000 || rsp_rdata !== 32'h0 ||
            ram_addr !== 10'h0 || ram_wdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset: rdy=%b vld=%b err=%b we=%b rdata=%h addr=%h wdata=%h, want all 0",
                     req_ready, rsp_valid, rsp_err, ram_we, rsp_rdata, ram_addr, ram_wdata);
        end
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_idle_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_load;
        logic [31:0] rd, wdat; logic e; int lat, nwe, wc; logic [9:0] wa; bit st, rs;
        poke(1, 32'hAABBCCDD);
        run_txn(3'd0, 12'h006, 32'h0, 0, 0, rd, e, lat, nwe, wc, wa, wdat, st, rs);
        n_tests++;
        if (lat !== 3) begin n_fail++; $display("FAIL lb_latency: got %0d want 3", lat); end
        n_tests++;
        if (rd !== 32'h000000BB || e !== 1'b0) begin n_fail++; $display("FAIL lb_data: got %h/%b want 000000bb/0", rd, e); end
        n_tests++;
        if (nwe !== 0 || rs) begin n_fail++; $display("FAIL lb_side: we=%0d ready_seen=%b want 0/0", nwe, rs); end
    endtask

    task automatic test_sb_rmw;
        logic [31:0] rd, wdat; logic e; int lat, nwe, wc; logic [9:0] wa; bit st, rs;
        run_txn(3'd5, 12'h005, 32'h12345677, 0, 0, rd, e, lat, nwe, wc, wa, wdat, st, rs);
        n_tests++;
        if (nwe !== 1 || wc !== 3 || wa !== 10'd1 || wdat !== 32'hAABB77DD) begin
            n_fail++; $display("FAIL sb_write: n=%0d cyc=%0d addr=%h data=%h want 1/3/001/aabb77dd", nwe, wc, wa, wdat);
        end
        n_tests++;
        if (lat !== 4 || rd !== 32'h0 || e !== 1'b0) begin n_fail++; $display("FAIL sb_resp: lat=%0d rd=%h err=%b want 4/0/0", lat, rd, e); end
        run_txn(3'd2, 12'h004, 32'h0, 0, 0, rd, e, lat, nwe, wc, wa, wdat, st, rs);
        n_tests++;
        if (rd !== 32'hAABB77DD || lat !== 3) begin n_fail++; $display("FAIL sb_readback: got %h lat %0d want aabb77dd lat 3", rd, lat); end
    endtask

    task automatic test_misaligned;
        logic [31:0] rd, wdat; logic e; int lat, nwe, wc; logic [9:0] wa; bit st, rs;
        run_txn(3'd1, 12'h003, 32'h0, 0, 0, rd, e, lat, nwe, wc, wa, wdat, st, rs);
        n_tests++;
        if (lat !== 1 || e !== 1'b1 || rd !== 32'h0 || nwe !== 0) begin
            n_fail++; $display("FAIL lh_misaligned: lat=%0d err=%b rd=%h we=%0d want 1/1/0/0", lat, e, rd, nwe);
        end
        run_txn(3'd7, 12'h00A, 32'hCAFEF00D, 0, 0, rd, e, lat, nwe, wc, wa, wdat, st, rs);
        n_tests++;
        if (lat !== 1 || e !== 1'b1 || rd !== 32'h0 || nwe !== 0) begin
            n_fail++; $display("FAIL sw_misaligned: lat=%0d err=%b rd=%h we=%0d want 1/1/0/0", lat, e, rd, nwe);
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] rd, wdat; logic e; int lat, nwe, wc; logic [9:0] wa; bit st, rs;
        run_txn(3'd7, 12'h008, 32'hDEADBEEF, 3, 1, rd, e, lat, nwe, wc, wa, wdat, st, rs);
        n_tests++;
        if (lat !== 2 || !st || rs) begin n_fail++; $display("FAIL sw_hold: lat=%0d stable=%b ready_seen=%b want 2/1/0", lat, st, rs); end
        n_tests++;
        if (nwe !== 1 || mem[2] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_ram: we=%0d ram2=%h want 1/deadbeef", nwe, mem[2]); end
        @(negedge clk);
        n_tests++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL busy_ignored: rdy=%b vld=%b want 1/0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_reset_midop;
        int we0;
        poke(1, 32'hAABBCCDD);
        we0 = 0;
        @(negedge clk);
        req_valid = 1'b1; req_ctrl = 3'd6; req_addr = 12'h006; req_wdata = 32'h0000BEEF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (2) begin @(negedge clk); if (ram_we) we0++; end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        if (ram_we) we0++;
        n_tests++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin n_fail++; $display("FAIL midop_reset: vld=%b rdy=%b want 0/0", rsp_valid, req_ready); end
        rst_n = 1'b1;
        repeat (3) begin @(negedge clk); if (ram_we) we0++; end
        n_tests++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || we0 !== 0 || mem[1] !== 32'hAABBCCDD) begin
            n_fail++; $display("FAIL midop_after: rdy=%b vld=%b we=%0d ram1=%h want 1/0/0/aabbccdd", req_ready, rsp_valid, we0, mem[1]);
        end
        // Reset landing exactly on the write cycle must suppress the strobe
        @(negedge clk);
        req_valid = 1'b1; req_ctrl = 3'd5; req_addr = 12'h005; req_wdata = 32'h00000011;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (ram_we !== 1'b0) begin n_fail++; $display("FAIL reset_in_write: we=%b want 0", ram_we); end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n_tests++;
        if (mem[1] !== 32'hAABBCCDD) begin n_fail++; $display("FAIL reset_in_write_ram: got %h want aabbccdd", mem[1]); end
    endtask

    task automatic test_sh_lhu;
        logic [31:0] rd, wdat; logic e; int lat, nwe, wc; logic [9:0] wa; bit st, rs;
        poke(1, 32'hAABBCCDD);
        run_txn(3'd6, 12'h006, 32'h0000BEEF, 0, 0, rd, e, lat, nwe, wc, wa, wdat, st, rs);
        n_tests++;
        if (lat !== 4 || nwe !== 1 || mem[1] !== 32'hBEEFCCDD) begin
            n_fail++; $display("FAIL sh_write: lat=%0d we=%0d ram1=%h want 4/1/beefccdd", lat, nwe, mem[1]);
        end
        run_txn(3'd4, 12'h006, 32'h0, 0, 0, rd, e, lat, nwe, wc, wa, wdat, st, rs);
        n_tests++;
        if (rd !== 32'h0000BEEF || e !== 1'b0) begin n_fail++; $display("FAIL lhu_read: got %h/%b want 0000beef/0", rd, e); end
    endtask

    task automatic test_random;
        logic [31:0] rd, wdat, erd, wd; logic e, ee; int lat, elat, nwe, wc; logic [9:0] wa;
        bit st, rs; logic [2:0] c; logic [11:0] a; int hold;
        for (int i = 0; i < 8; i++) poke(i, $urandom);
        for (int i = 0; i < 60; i++) begin
            c = 3'($urandom_range(0, 7));
            a = 12'($urandom_range(0, 31));
            wd = $urandom;
            hold = $urandom_range(0, 2);
            ref_apply(c, a, wd, erd, ee, elat);
            run_txn(c, a, wd, hold, 0, rd, e, lat, nwe, wc, wa, wdat, st, rs);
            n_tests++;
            if (rd !== erd || e !== ee || lat !== elat || !st) begin
                n_fail++; $display("FAIL rand_%0d op=%0d addr=%h: rd=%h err=%b lat=%0d stable=%b want %h/%b/%0d/1",
                                   i, c, a, rd, e, lat, st, erd, ee, elat);
            end
            n_tests++;
            if (nwe !== ((c >= 3'd5 && !ee) ? 1 : 0) || (nwe == 1 && (wa !== a[11:2] || wc !== elat - 1))) begin
                n_fail++; $display("FAIL rand_we_%0d op=%0d addr=%h: n=%0d addr=%h cyc=%0d", i, c, a, nwe, wa, wc);
            end
        end
        for (int w = 0; w < 8; w++) begin
            n_tests++;
            if (mem[w] !== ref_mem[w]) begin n_fail++; $display("FAIL rand_ram_%0d: got %h want %h", w, mem[w], ref_mem[w]); end
        end
    endtask

    initial begin
        test_reset;
        test_load;
        test_sb_rmw;
        test_misaligned;
        test_backpressure;
        test_reset_midop;
        test_sh_lhu;
        test_random;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
